// File: rtl/taylor_axil_regs_if.sv
// AXI4-Lite bus bundle between the block-design master and the Taylor register file.
// A transfer happens on a rising edge where valid and ready are both high; valid never waits on ready.
interface taylor_axil_regs_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/taylor_axil_regs.sv
// AXI4-Lite slave holding four 32-bit control registers for the Taylor core.
// AW and W are buffered independently; a write commits once both are held and no response is pending.
module taylor_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    taylor_axil_regs_if.slave s_axi,
    output logic [31:0] reg0_o,
    output logic [31:0] reg1_o,
    output logic [31:0] reg2_o,
    output logic [31:0] reg3_o,
    output logic [3:0]  reg_wr_pulse
);
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
    localparam int IDX_HI = C_S_AXI_ADDR_WIDTH - 1;
    localparam int IDX_LO = C_S_AXI_ADDR_WIDTH - 2;

    logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
    logic                          aw_full;
    logic [1:0]                    aw_idx;
    logic                          w_full;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]             w_strb;

    logic aw_hs, w_hs, ar_hs, commit, b_done, r_done;
    logic aw_full_nx, w_full_nx, bvalid_nx, rvalid_nx;
    logic unused_bits;

    assign aw_hs  = s_axi.awvalid & s_axi.awready;
    assign w_hs   = s_axi.wvalid & s_axi.wready;
    assign ar_hs  = s_axi.arvalid & s_axi.arready;
    assign commit = aw_full & w_full & ~s_axi.bvalid;
    assign b_done = s_axi.bvalid & s_axi.bready;
    assign r_done = s_axi.rvalid & s_axi.rready;

    assign s_axi.bresp = 2'b00;
    assign s_axi.rresp = 2'b00;

    assign reg0_o = regs[0];
    assign reg1_o = regs[1];
    assign reg2_o = regs[2];
    assign reg3_o = regs[3];

    assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[IDX_LO-1:0], s_axi.araddr[IDX_LO-1:0]};

    function automatic logic [C_S_AXI_DATA_WIDTH-1:0] merge_bytes(
        input logic [C_S_AXI_DATA_WIDTH-1:0] old_val,
        input logic [C_S_AXI_DATA_WIDTH-1:0] new_val,
        input logic [STRB_W-1:0]             strb
    );
        logic [C_S_AXI_DATA_WIDTH-1:0] res;
        res = old_val;
        for (int k = 0; k < STRB_W; k++) begin
            if (strb[k]) res[k*8 +: 8] = new_val[k*8 +: 8];
        end
        return res;
    endfunction

    // Next-state of the buffers and valids; readies are registered copies derived from these.
    always_comb begin
        aw_full_nx = aw_full;
        w_full_nx  = w_full;
        bvalid_nx  = s_axi.bvalid;
        rvalid_nx  = s_axi.rvalid;
        if (commit)     aw_full_nx = 1'b0;
        else if (aw_hs) aw_full_nx = 1'b1;
        if (commit)     w_full_nx = 1'b0;
        else if (w_hs)  w_full_nx = 1'b1;
        if (commit)      bvalid_nx = 1'b1;
        else if (b_done) bvalid_nx = 1'b0;
        if (ar_hs)       rvalid_nx = 1'b1;
        else if (r_done) rvalid_nx = 1'b0;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            aw_full       <= 1'b0;
            aw_idx        <= 2'b00;
            w_full        <= 1'b0;
            w_data        <= '0;
            w_strb        <= '0;
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b0;
            s_axi.bvalid  <= 1'b0;
            s_axi.arready <= 1'b0;
            s_axi.rvalid  <= 1'b0;
            s_axi.rdata   <= '0;
            reg_wr_pulse  <= 4'b0000;
        end else begin
            aw_full       <= aw_full_nx;
            w_full        <= w_full_nx;
            s_axi.bvalid  <= bvalid_nx;
            s_axi.rvalid  <= rvalid_nx;
            s_axi.awready <= ~aw_full_nx & ~bvalid_nx;
            s_axi.wready  <= ~w_full_nx & ~bvalid_nx;
            s_axi.arready <= ~rvalid_nx;
            if (aw_hs) aw_idx <= s_axi.awaddr[IDX_HI:IDX_LO];
            if (w_hs) begin
                w_data <= s_axi.wdata;
                w_strb <= s_axi.wstrb;
            end
            if (commit) regs[aw_idx] <= merge_bytes(regs[aw_idx], w_data, w_strb);
            reg_wr_pulse <= commit ? (4'b0001 << aw_idx) : 4'b0000;
            // Sampled before this edge's commit lands, so a coinciding read sees the old value.
            if (ar_hs) s_axi.rdata <= regs[s_axi.araddr[IDX_HI:IDX_LO]];
        end
    end
endmodule

// File: tb/tb_taylor_axil_regs.sv
// Directed bench for taylor_axil_regs: drives on the falling edge, samples on the falling edge.
module tb_taylor_axil_regs;
    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b1;
    logic [31:0] reg0_o, reg1_o, reg2_o, reg3_o;
    logic [3:0]  reg_wr_pulse;
    int          checks = 0;
    int          errors = 0;

    taylor_axil_regs_if bus ();

    taylor_axil_regs dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .s_axi        (bus),
        .reg0_o       (reg0_o),
        .reg1_o       (reg1_o),
        .reg2_o       (reg2_o),
        .reg3_o       (reg3_o),
        .reg_wr_pulse (reg_wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic bus_idle();
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
    endtask

    // Called at a falling edge; returns at a falling edge after the B handshake.
    task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] bresp, output logic [3:0] pulse, output logic ok);
        bit aw_done, w_done, aw_fire, w_fire;
        int cnt;
        aw_done = 0; w_done = 0; cnt = 0; ok = 1'b1; bresp = 2'bxx; pulse = 4'bxxxx;
        bus.awaddr = addr; bus.awvalid = 1'b1;
        bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
        while (!(aw_done && w_done) && cnt < 50) begin
            aw_fire = bus.awvalid && bus.awready;
            w_fire  = bus.wvalid && bus.wready;
            @(negedge ACLK); cnt++;
            if (aw_fire) begin bus.awvalid = 1'b0; aw_done = 1; end
            if (w_fire)  begin bus.wvalid = 1'b0;  w_done = 1;  end
        end
        while (!bus.bvalid && cnt < 50) begin @(negedge ACLK); cnt++; end
        if (!bus.bvalid) begin
            ok = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
            return;
        end
        bresp = bus.bresp; pulse = reg_wr_pulse;
        bus.bready = 1'b1;
        @(negedge ACLK);
        bus.bready = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] addr, output logic [31:0] data,
                           output logic [1:0] rresp, output logic ok);
        int cnt;
        cnt = 0; ok = 1'b1; data = 'x; rresp = 2'bxx;
        bus.araddr = addr; bus.arvalid = 1'b1;
        while (!bus.arready && cnt < 50) begin @(negedge ACLK); cnt++; end
        @(negedge ACLK);
        bus.arvalid = 1'b0;
        while (!bus.rvalid && cnt < 50) begin @(negedge ACLK); cnt++; end
        if (!bus.rvalid) begin ok = 1'b0; return; end
        data = bus.rdata; rresp = bus.rresp;
        bus.rready = 1'b1;
        @(negedge ACLK);
        bus.rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] flags;
        bus_idle();
        #1 ARESETN = 1'b0;
        repeat (2) @(negedge ACLK);
        flags = {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.bresp, 1'b0};
        checks++;
        if (flags !== 8'h00) begin errors++; $display("FAIL reset_flags got %h want 00", flags); end
        checks++;
        if ({reg0_o, reg1_o, reg2_o, reg3_o, bus.rdata, reg_wr_pulse} !== '0) begin
            errors++; $display("FAIL reset_regs got %h %h %h %h %h %b", reg0_o, reg1_o, reg2_o, reg3_o, bus.rdata, reg_wr_pulse);
        end
        ARESETN = 1'b1;
        checks++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin
            errors++; $display("FAIL ready_before_edge got %b want 000", {bus.awready, bus.wready, bus.arready});
        end
        @(negedge ACLK);
        checks++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
            errors++; $display("FAIL ready_after_edge got %b want 111", {bus.awready, bus.wready, bus.arready});
        end
    endtask

    task automatic test_sequential();
        logic [1:0] resp; logic [3:0] pulse; logic ok; logic [31:0] data;
        for (int i = 0; i < 4; i++) begin
            do_write(4'(i * 4), 32'(i + 1), 4'hF, resp, pulse, ok);
            checks++;
            if (!ok || resp !== 2'b00) begin errors++; $display("FAIL seq_bresp[%0d] ok %b got %b want 00", i, ok, resp); end
            checks++;
            if (pulse !== (4'b0001 << i)) begin errors++; $display("FAIL seq_pulse[%0d] got %b want %b", i, pulse, 4'b0001 << i); end
        end
        checks++;
        if (reg_wr_pulse !== 4'b0000) begin errors++; $display("FAIL pulse_one_cycle got %b want 0000", reg_wr_pulse); end
        checks++;
        if ({reg0_o, reg1_o, reg2_o, reg3_o} !== {32'h1, 32'h2, 32'h3, 32'h4}) begin
            errors++; $display("FAIL seq_regs got %h %h %h %h want 1 2 3 4", reg0_o, reg1_o, reg2_o, reg3_o);
        end
        for (int i = 0; i < 4; i++) begin
            do_read(4'(i * 4), data, resp, ok);
            checks++;
            if (!ok || data !== 32'(i + 1) || resp !== 2'b00) begin
                errors++; $display("FAIL seq_read[%0d] ok %b got %h/%b want %h/00", i, ok, data, resp, i + 1);
            end
        end
    endtask

    task automatic test_partial_strobe();
        logic [1:0] resp; logic [3:0] pulse; logic ok; logic [31:0] data;
        do_write(4'h4, 32'hAABBCCDD, 4'hF, resp, pulse, ok);
        do_write(4'h5, 32'h11223344, 4'b0101, resp, pulse, ok);
        checks++;
        if (reg1_o !== 32'hAA22CC44) begin errors++; $display("FAIL strobe_reg1 got %h want AA22CC44", reg1_o); end
        do_read(4'h4, data, resp, ok);
        checks++;
        if (!ok || data !== 32'hAA22CC44) begin errors++; $display("FAIL strobe_read ok %b got %h want AA22CC44", ok, data); end
    endtask

    task automatic test_channel_skew();
        bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge ACLK);
        bus.wvalid = 1'b0;
        checks++;
        if (bus.wready !== 1'b0) begin errors++; $display("FAIL skew_wready got %b want 0", bus.wready); end
        repeat (2) @(negedge ACLK);
        checks++;
        if (bus.bvalid !== 1'b0 || reg2_o !== 32'h3) begin
            errors++; $display("FAIL skew_lone_w bvalid %b reg2 %h want 0/00000003", bus.bvalid, reg2_o);
        end
        bus.awaddr = 4'h8; bus.awvalid = 1'b1;
        checks++;
        if (bus.awready !== 1'b1) begin errors++; $display("FAIL skew_awready got %b want 1", bus.awready); end
        @(negedge ACLK);
        bus.awvalid = 1'b0;
        checks++;
        if (bus.bvalid !== 1'b0 || reg2_o !== 32'h3) begin
            errors++; $display("FAIL skew_early_commit bvalid %b reg2 %h want 0/00000003", bus.bvalid, reg2_o);
        end
        @(negedge ACLK);
        checks++;
        if (bus.bvalid !== 1'b1 || reg2_o !== 32'hDEADBEEF || reg_wr_pulse !== 4'b0100) begin
            errors++; $display("FAIL skew_commit bvalid %b reg2 %h pulse %b want 1/DEADBEEF/0100", bus.bvalid, reg2_o, reg_wr_pulse);
        end
        bus.bready = 1'b1;
        @(negedge ACLK);
        bus.bready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        bus.awaddr = 4'h0; bus.awvalid = 1'b1;
        bus.wdata = 32'h0A0A0A0A; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge ACLK);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(negedge ACLK);
        bus.awaddr = 4'h0; bus.awvalid = 1'b1;
        bus.wdata = 32'h0B0B0B0B; bus.wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.bvalid, bus.awready, bus.wready} !== 3'b100 || reg0_o !== 32'h0A0A0A0A) begin
                errors++; $display("FAIL bp_hold[%0d] bvalid/awready/wready %b reg0 %h want 100/0A0A0A0A", i,
                                   {bus.bvalid, bus.awready, bus.wready}, reg0_o);
            end
            @(negedge ACLK);
        end
        bus.bready = 1'b1;
        @(negedge ACLK);
        bus.bready = 1'b0;
        checks++;
        if ({bus.bvalid, bus.awready, bus.wready} !== 3'b011) begin
            errors++; $display("FAIL bp_release got %b want 011", {bus.bvalid, bus.awready, bus.wready});
        end
        @(negedge ACLK);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(negedge ACLK);
        checks++;
        if (bus.bvalid !== 1'b1 || reg0_o !== 32'h0B0B0B0B) begin
            errors++; $display("FAIL bp_second bvalid %b reg0 %h want 1/0B0B0B0B", bus.bvalid, reg0_o);
        end
        bus.bready = 1'b1;
        @(negedge ACLK);
        bus.bready = 1'b0;
        bus.araddr = 4'h0; bus.arvalid = 1'b1;
        @(negedge ACLK);
        bus.arvalid = 1'b0;
        held = bus.rdata;
        checks++;
        if (bus.rvalid !== 1'b1 || held !== 32'h0B0B0B0B) begin
            errors++; $display("FAIL bp_rdata rvalid %b got %h want 1/0B0B0B0B", bus.rvalid, held);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            checks++;
            if (bus.rvalid !== 1'b1 || bus.arready !== 1'b0 || bus.rdata !== 32'h0B0B0B0B) begin
                errors++; $display("FAIL bp_rhold[%0d] rvalid %b arready %b rdata %h want 1/0/0B0B0B0B", i,
                                   bus.rvalid, bus.arready, bus.rdata);
            end
        end
        bus.rready = 1'b1;
        @(negedge ACLK);
        bus.rready = 1'b0;
        checks++;
        if ({bus.rvalid, bus.arready} !== 2'b01) begin
            errors++; $display("FAIL bp_rrelease got %b want 01", {bus.rvalid, bus.arready});
        end
    endtask

    task automatic test_collision();
        logic [1:0] resp; logic ok; logic [31:0] data;
        bus.awaddr = 4'hC; bus.awvalid = 1'b1;
        bus.wdata = 32'h55; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge ACLK);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.araddr = 4'hC; bus.arvalid = 1'b1;
        @(negedge ACLK);
        bus.arvalid = 1'b0;
        checks++;
        if (bus.bvalid !== 1'b1 || bus.rvalid !== 1'b1 || bus.rdata !== 32'h4 || reg3_o !== 32'h55) begin
            errors++; $display("FAIL collide_old bvalid %b rvalid %b rdata %h reg3 %h want 1/1/00000004/00000055",
                               bus.bvalid, bus.rvalid, bus.rdata, reg3_o);
        end
        bus.bready = 1'b1; bus.rready = 1'b1;
        @(negedge ACLK);
        bus.bready = 1'b0; bus.rready = 1'b0;
        do_read(4'hC, data, resp, ok);
        checks++;
        if (!ok || data !== 32'h55) begin errors++; $display("FAIL collide_new ok %b got %h want 00000055", ok, data); end
    endtask

    task automatic test_midop_reset();
        logic [1:0] resp; logic ok; logic [31:0] data;
        bus.awaddr = 4'h4; bus.awvalid = 1'b1;
        bus.wdata = 32'h77; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        bus.araddr = 4'h0; bus.arvalid = 1'b1;
        @(negedge ACLK);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        @(negedge ACLK);
        checks++;
        if ({bus.bvalid, bus.rvalid} !== 2'b11) begin
            errors++; $display("FAIL midop_pending got %b want 11", {bus.bvalid, bus.rvalid});
        end
        #2 ARESETN = 1'b0;
        #1;
        checks++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.rdata,
             reg0_o, reg1_o, reg2_o, reg3_o, reg_wr_pulse} !== '0) begin
            errors++; $display("FAIL midop_async rdy %b%b%b bv %b rv %b rdata %h regs %h %h %h %h pulse %b want all 0",
                               bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.rdata,
                               reg0_o, reg1_o, reg2_o, reg3_o, reg_wr_pulse);
        end
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        for (int i = 0; i < 4; i++) begin
            do_read(4'(i * 4), data, resp, ok);
            checks++;
            if (!ok || data !== 32'h0) begin errors++; $display("FAIL midop_read[%0d] ok %b got %h want 0", i, ok, data); end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_partial_strobe();
        test_channel_skew();
        test_backpressure();
        test_collision();
        test_midop_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/taylor_axil_regs.md
Name: taylor_axil_regs

Overview:
- AXI4-Lite slave (responder) register file for the Taylor-approximation IP.
- Accepts single-beat AXI4-Lite writes and reads from the block-design master.
- Holds four 32-bit read/write registers, exported to the Taylor core with per-register write-strobe pulses.
- Sits between the S00_AXI interface and the Taylor datapath; it is the slave end of the master's AXI4LITE_WRITE_BURST / AXI4LITE_READ_BURST traffic.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; addr[3:2] selects register, addr[1:0] ignored.

Ports:
- ACLK  in  1  system clock, all logic on rising edge.
- ARESETN  in  1  reset, asynchronous assert, active-low.
- S_AXI_AWADDR  in  4  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP  out  2  write response, always 2'b00.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR  in  4  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response, always 2'b00.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.
- reg0_o..reg3_o  out  32 each  current register contents to the Taylor core.
- reg_wr_pulse  out  4  one-cycle pulse per register, asserted on commit.

Behaviour:
- Reset (ARESETN low, asynchronous): every output and register goes to 0, including all READY/VALID, RDATA, reg*_o and reg_wr_pulse. In-flight transactions are dropped.
- AWREADY, WREADY and ARREADY rise on the first clock edge after ARESETN is sampled high.
- Write path, AW and W handled independently:
  - AW handshake (AWVALID & AWREADY) latches the address into aw_buf; AWREADY drops while aw_buf is full.
  - W handshake latches data and strobe into w_buf; WREADY drops while w_buf is full.
  - AW and W may arrive in either order or in the same cycle. A lone AW or W waits indefinitely.
- Write commit:
  - Occurs on the first edge where both buffers are full and BVALID is low.
  - Target register is selected by aw_buf[3:2]. Byte k updates only if wstrb[k]=1.
  - Same edge: BVALID rises, reg_wr_pulse[idx] asserts for exactly one cycle, both buffers clear.
  - If both handshakes happen in the same cycle, commit is on the following edge.
- Write response:
  - BVALID holds until BREADY is sampled high, then clears.
  - AWREADY/WREADY re-assert only once their buffer is empty and BVALID is low (or clearing the same cycle).
  - At most one write outstanding.
- Read path:
  - ARREADY is high whenever RVALID is low.
  - AR handshake captures the selected register into RDATA and sets RVALID on the next edge.
  - RDATA and RVALID stay stable until RREADY; ARREADY is low meanwhile.
  - Maximum throughput is one read per 2 cycles when RREADY is held high.
- Read/write collision: a read whose AR handshake precedes or coincides with a commit edge to the same register returns the pre-write value. Any later read returns the new value.
- Read and write channels operate concurrently with no arbitration stall.
- Responses: BRESP and RRESP are always OKAY. No decode error is possible, since the 4-bit address covers all registers.
- Bus behaviour: protocol is AXI4-Lite only (no ID/LEN/burst); AWPROT and ARPROT are unused.

Test Plan:
- Post-reset sequential: write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC (WSTRB=F), then read 0x0..0xC -> RDATA 0x1..0x4, all BRESP/RRESP=00, reg_wr_pulse shows 0001,0010,0100,1000 in turn.
- Partial strobe: reg1=0xAABBCCDD, write 0x11223344 with WSTRB=0101 to 0x4 -> read returns 0xAA22CC44.
- Channel skew: drive W 3 cycles before AW at 0x8, data 0xDEADBEEF -> WREADY low after W handshake, commit one edge after AW handshake, reg2_o=0xDEADBEEF.
- Backpressure: hold BREADY=0 for 5 cycles after a write, offer a second AW/W -> BVALID steady, second write not accepted until B handshake. Hold RREADY=0 -> RDATA stable, ARREADY=0.
- Collision: AR at 0xC issued in the commit cycle of a write 0x55 to 0xC where the old value is 0x4 -> read returns 0x4; next read returns 0x55.
- Mid-op reset: drop ARESETN with BVALID=1 and RVALID=1 -> all outputs 0 immediately (asynchronous), registers 0, readback after release returns 0.
